// File: rtl/pnr_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pnr_pkg
// Description : Shared widths, FSM state encoding and threshold-slice helper
//               for the PNR photon classifier.
// Revision    : 1.0 - initial release
// ============================================================================
package pnr_pkg;

  localparam int ADC_W    = 14;
  localparam int WIN_W    = 8;
  localparam int ACC_W    = ADC_W + WIN_W;
  localparam int HIST_W   = 32;
  localparam int NUM_TH   = 7;
  localparam int NUM_BINS = NUM_TH + 1;
  localparam int MISS_W   = 16;

  // FSM state encoding
  typedef logic [1:0] state_t;
  localparam logic [1:0] IDLE     = 2'd0;
  localparam logic [1:0] INTEG    = 2'd1;
  localparam logic [1:0] CLASSIFY = 2'd2;

  // Extract threshold k from the packed ladder: bits [(k+1)*ACC_W-1 : k*ACC_W]
  function automatic logic signed [ACC_W-1:0] th_slice(
    input logic [NUM_TH*ACC_W-1:0] vec,
    input int unsigned             k
  );
    return $signed(vec[k*ACC_W +: ACC_W]);
  endfunction

endpackage
`default_nettype wire

// File: rtl/pnr_histogram.sv
`default_nettype none
// ============================================================================
// Module      : pnr_histogram
// Description : Eight saturating per-photon-number bins plus a saturating
//               missed-trigger counter. Clear has priority over increments.
//               The selected bin is presented through a registered read port.
// Revision    : 1.0 - initial release
// ============================================================================
module pnr_histogram #(
  parameter int HIST_W = pnr_pkg::HIST_W,
  parameter int MISS_W = pnr_pkg::MISS_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_clr,
  input  logic              i_inc,
  input  logic [2:0]        i_inc_bin,
  input  logic              i_miss,
  input  logic [2:0]        i_addr,
  output logic [HIST_W-1:0] o_data,
  output logic [MISS_W-1:0] o_missed_cnt
);
  import pnr_pkg::*;

  logic [HIST_W-1:0] w_bin [NUM_BINS];

  for (genvar gi = 0; gi < NUM_BINS; gi++) begin : g_bin
    logic [HIST_W-1:0] r_bin;

    // One bin: clear wins, otherwise count up and stick at all-ones
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_bin <= '0;
      end else if (i_clr) begin
        r_bin <= '0;
      end else if (i_inc && (i_inc_bin == 3'(gi)) && (r_bin != '1)) begin
        r_bin <= r_bin + HIST_W'(1);
      end
    end

    assign w_bin[gi] = r_bin;
  end

  // Dropped-trigger counter, saturating, cleared together with the bins
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_missed_cnt <= '0;
    end else if (i_clr) begin
      o_missed_cnt <= '0;
    end else if (i_miss && (o_missed_cnt != '1)) begin
      o_missed_cnt <= o_missed_cnt + MISS_W'(1);
    end
  end

  // Registered read port, one cycle latency from i_addr
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_data <= '0;
    end else begin
      o_data <= w_bin[i_addr];
    end
  end

endmodule
`default_nettype wire

// File: rtl/pnr_photon_classifier.sv
`default_nettype none
// ============================================================================
// Module      : pnr_photon_classifier
// Description : Integrates the ADC signal over a programmable window after
//               each delayed trigger, classifies the integral against a
//               seven-step threshold ladder into a photon number 0..7 and
//               keeps a per-number histogram plus a missed-trigger count.
// Revision    : 1.0 - initial release
// ============================================================================
module pnr_photon_classifier #(
  parameter int ADC_W  = pnr_pkg::ADC_W,
  parameter int WIN_W  = pnr_pkg::WIN_W,
  parameter int ACC_W  = pnr_pkg::ACC_W,
  parameter int HIST_W = pnr_pkg::HIST_W
) (
  input  logic                     ADC_CLK,
  input  logic                     rstn_i,
  input  logic signed [ADC_W-1:0]  adc_sig,
  input  logic                     delayed_trigger,
  input  logic [WIN_W-1:0]         win_len,
  input  logic [7*ACC_W-1:0]       pnr_thresh,
  input  logic                     hist_clr,
  input  logic [2:0]               hist_addr,
  output logic [HIST_W-1:0]        hist_data,
  output logic                     pnr_valid,
  output logic [2:0]               pnr_num,
  output logic signed [ACC_W-1:0]  pnr_sum,
  output logic                     busy,
  output logic [15:0]              missed_cnt
);
  import pnr_pkg::*;

  state_t                  r_state;
  logic signed [ACC_W-1:0] r_acc;
  logic [WIN_W-1:0]        r_rem;
  logic signed [ACC_W-1:0] r_th [NUM_TH];

  logic [WIN_W-1:0]        w_len;
  logic signed [ACC_W-1:0] w_sample;
  logic [2:0]              w_num;
  logic                    w_classify;
  logic                    w_miss;

  // A zero window length is treated as a single sample
  assign w_len      = (win_len == '0) ? WIN_W'(1) : win_len;
  assign w_sample   = {{WIN_W{adc_sig[ADC_W-1]}}, adc_sig};
  assign busy       = (r_state != IDLE);
  assign w_classify = (r_state == CLASSIFY);
  assign w_miss     = delayed_trigger && busy;

  // Ladder: count thresholds met; a non-monotonic ladder is simply counted
  always_comb begin
    w_num = '0;
    for (int k = 0; k < NUM_TH; k++) begin
      if (r_acc >= r_th[k]) begin
        w_num = w_num + 3'd1;
      end
    end
  end

  // Event FSM and accumulator; a one-sample window skips INTEG entirely so
  // that CLASSIFY always lands L cycles after the trigger
  always_ff @(posedge ADC_CLK or negedge rstn_i) begin
    if (!rstn_i) begin
      r_state <= IDLE;
      r_acc   <= '0;
      r_rem   <= '0;
      for (int k = 0; k < NUM_TH; k++) begin
        r_th[k] <= '0;
      end
    end else begin
      case (r_state)
        IDLE: begin
          if (delayed_trigger) begin
            r_acc <= w_sample;
            r_rem <= w_len - WIN_W'(1);
            for (int k = 0; k < NUM_TH; k++) begin
              r_th[k] <= th_slice(pnr_thresh, k);
            end
            r_state <= (w_len == WIN_W'(1)) ? CLASSIFY : INTEG;
          end
        end
        INTEG: begin
          r_acc <= r_acc + w_sample;
          r_rem <= r_rem - WIN_W'(1);
          if (r_rem == WIN_W'(1)) begin
            r_state <= CLASSIFY;
          end
        end
        CLASSIFY: begin
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  // Result registers: strobe for one cycle, number and sum held
  always_ff @(posedge ADC_CLK or negedge rstn_i) begin
    if (!rstn_i) begin
      pnr_valid <= 1'b0;
      pnr_num   <= '0;
      pnr_sum   <= '0;
    end else begin
      pnr_valid <= w_classify;
      if (w_classify) begin
        pnr_num <= w_num;
        pnr_sum <= r_acc;
      end
    end
  end

  pnr_histogram #(
    .HIST_W (HIST_W),
    .MISS_W (16)
  ) u_hist (
    .clk          (ADC_CLK),
    .rst_n        (rstn_i),
    .i_clr        (hist_clr),
    .i_inc        (w_classify),
    .i_inc_bin    (w_num),
    .i_miss       (w_miss),
    .i_addr       (hist_addr),
    .o_data       (hist_data),
    .o_missed_cnt (missed_cnt)
  );

endmodule
`default_nettype wire

// File: tb/tb_pnr_photon_classifier.sv
`default_nettype none
// ============================================================================
// Module      : tb_pnr_photon_classifier
// Description : Scoreboard bench for pnr_photon_classifier. Stimulus pushes
//               the expected result and its arrival cycle; a monitor pops and
//               compares on every pnr_valid.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pnr_photon_classifier;
  import pnr_pkg::*;

  logic                    ADC_CLK = 1'b0;
  logic                    rstn_i = 1'b0;
  logic signed [13:0]      adc_sig = '0;
  logic                    delayed_trigger = 1'b0;
  logic [7:0]              win_len = '0;
  logic [7*22-1:0]         pnr_thresh = '0;
  logic                    hist_clr = 1'b0;
  logic [2:0]              hist_addr = '0;
  logic [31:0]             hist_data;
  logic                    pnr_valid;
  logic [2:0]              pnr_num;
  logic signed [21:0]      pnr_sum;
  logic                    busy;
  logic [15:0]             missed_cnt;

  typedef struct {
    logic [2:0]         num;
    logic signed [21:0] sum;
    int                 cyc;
  } exp_t;

  exp_t q[$];
  int   tests = 0;
  int   fails = 0;
  int   cyc = 0;

  pnr_photon_classifier u_dut (
    .ADC_CLK         (ADC_CLK),
    .rstn_i          (rstn_i),
    .adc_sig         (adc_sig),
    .delayed_trigger (delayed_trigger),
    .win_len         (win_len),
    .pnr_thresh      (pnr_thresh),
    .hist_clr        (hist_clr),
    .hist_addr       (hist_addr),
    .hist_data       (hist_data),
    .pnr_valid       (pnr_valid),
    .pnr_num         (pnr_num),
    .pnr_sum         (pnr_sum),
    .busy            (busy),
    .missed_cnt      (missed_cnt)
  );

  always #5 ADC_CLK = ~ADC_CLK;

  always @(posedge ADC_CLK) cyc <= cyc + 1;

  task automatic check(input string name, input longint act, input longint req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge ADC_CLK);
  endtask

  task automatic set_ladder(input int t0, input int t1, input int t2, input int t3,
                            input int t4, input int t5, input int t6);
    logic [7*22-1:0] v;
    v = '0;
    v[0*22 +: 22] = 22'(t0);
    v[1*22 +: 22] = 22'(t1);
    v[2*22 +: 22] = 22'(t2);
    v[3*22 +: 22] = 22'(t3);
    v[4*22 +: 22] = 22'(t4);
    v[5*22 +: 22] = 22'(t5);
    v[6*22 +: 22] = 22'(t6);
    pnr_thresh = v;
  endtask

  // One-cycle trigger; when accepted, the result is due in cycle T+L+1
  task automatic fire(input bit expect_it, input logic [2:0] num, input int sum);
    int   len;
    exp_t e;
    len = (win_len == 8'd0) ? 1 : int'(win_len);
    if (expect_it) begin
      e.num = num;
      e.sum = 22'(sum);
      e.cyc = cyc + len + 1;
      q.push_back(e);
    end
    delayed_trigger = 1'b1;
    @(negedge ADC_CLK);
    delayed_trigger = 1'b0;
  endtask

  // Monitor: every pnr_valid must match the oldest expected result
  always @(negedge ADC_CLK) begin
    if (rstn_i && pnr_valid) begin
      if (q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_valid: pnr_valid=1 in cycle %0d, required 0", cyc);
      end else begin
        exp_t e;
        e = q.pop_front();
        check("valid_cycle", cyc, e.cyc);
        check("pnr_num", pnr_num, e.num);
        check("pnr_sum", pnr_sum, e.sum);
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    tick(3);
    check("rst_valid", pnr_valid, 0);
    check("rst_num", pnr_num, 0);
    check("rst_sum", pnr_sum, 0);
    check("rst_busy", busy, 0);
    check("rst_missed", missed_cnt, 0);
    check("rst_hist", hist_data, 0);
    rstn_i = 1'b1;
    tick(2);

    // Constant input, window 4
    adc_sig = 14'sd100;
    win_len = 8'd4;
    set_ladder(0, 300, 500, 700, 900, 1100, 1300);
    hist_addr = 3'd2;
    fire(1'b1, 3'd2, 400);
    check("busy_during_event", busy, 1);
    tick(8);
    check("bin2_after_event", hist_data, 1);
    check("busy_after_event", busy, 0);

    // Zero window behaves as one sample, all thresholds met
    adc_sig = -14'sd50;
    win_len = 8'd0;
    set_ladder(-60, -60, -60, -60, -60, -60, -60);
    hist_addr = 3'd7;
    fire(1'b1, 3'd7, -50);
    tick(5);
    check("bin7_after_win0", hist_data, 1);

    // Re-trigger while busy is dropped; T+9 is accepted
    adc_sig = 14'sd10;
    win_len = 8'd8;
    set_ladder(0, 300, 500, 700, 900, 1100, 1300);
    hist_addr = 3'd1;
    fire(1'b1, 3'd1, 80);
    tick(2);
    fire(1'b0, 3'd0, 0);
    tick(5);
    fire(1'b1, 3'd1, 80);
    tick(12);
    check("missed_after_retrigger", missed_cnt, 1);
    check("bin1_two_events", hist_data, 2);

    // Extremes over a 255-sample window
    set_ladder(-2088960, -2088959, 0, 1, 2, 3, 2088705);
    win_len = 8'd255;
    adc_sig = -14'sd8192;
    fire(1'b1, 3'd1, -2088960);
    tick(260);
    adc_sig = 14'sd8191;
    fire(1'b1, 3'd7, 2088705);
    tick(260);
    hist_addr = 3'd7;
    tick(2);
    check("bin7_after_extremes", hist_data, 2);

    // Clear coinciding with the CLASSIFY increment of bin 3
    set_ladder(0, 300, 500, 700, 900, 1100, 1300);
    adc_sig = 14'sd100;
    win_len = 8'd6;
    hist_addr = 3'd3;
    fire(1'b1, 3'd3, 600);
    tick(5);
    hist_clr = 1'b1;
    tick(1);
    hist_clr = 1'b0;
    tick(3);
    check("bin3_clear_wins", hist_data, 0);
    check("missed_cleared", missed_cnt, 0);
    hist_addr = 3'd1;
    tick(2);
    check("bin1_cleared", hist_data, 0);
    hist_addr = 3'd3;
    fire(1'b1, 3'd3, 600);
    tick(10);
    check("bin3_after_clear", hist_data, 1);

    // Saturation of bin 5
    force u_dut.u_hist.g_bin[5].r_bin = 32'hFFFF_FFFF;
    tick(1);
    release u_dut.u_hist.g_bin[5].r_bin;
    hist_addr = 3'd5;
    tick(2);
    check("bin5_preload", hist_data, 32'hFFFF_FFFF);
    win_len = 8'd10;
    fire(1'b1, 3'd5, 1000);
    tick(14);
    check("bin5_saturated", hist_data, 32'hFFFF_FFFF);

    // Reset mid-event aborts it
    win_len = 8'd10;
    fire(1'b0, 3'd0, 0);
    tick(1);
    rstn_i = 1'b0;
    #1;
    check("abort_valid", pnr_valid, 0);
    check("abort_num", pnr_num, 0);
    check("abort_sum", pnr_sum, 0);
    check("abort_busy", busy, 0);
    check("abort_hist", hist_data, 0);
    tick(2);
    rstn_i = 1'b1;
    tick(12);
    win_len = 8'd4;
    fire(1'b1, 3'd2, 400);
    tick(8);

    check("scoreboard_drained", q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
